// File: rtl/ex_mem_stage_pkg.sv
// Shared opcode map, flag indices and FSM state type for the EX/MEM stage.
// Opcode values mirror the core-wide define set; no new opcodes are introduced here.
package ex_mem_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_NF = 2;

    localparam logic [15:0] NOP_IR = 16'h0000;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } run_state_t;

    function automatic logic op_is_add(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_ADDC);
    endfunction

    // CMP is a subtract that only keeps the flags, so it shares the SUB rules.
    function automatic logic op_is_sub(input logic [4:0] op);
        return (op == OP_SUB) || (op == OP_SUBI) || (op == OP_SUBC) || (op == OP_CMP);
    endfunction

    function automatic logic op_is_logic(input logic [4:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
               (op == OP_SLL) || (op == OP_SRL) || (op == OP_SLA) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Maps an opcode and the current flag register to a branch-taken decision.
// Purely combinational; also consumed by the hazard unit.
module ex_mem_stage_branch_resolve
    import ex_mem_stage_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       zf,
    input  logic       nf,
    input  logic       cf,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JMPR: taken = 1'b1;
            OP_BZ:   taken = zf;
            OP_BNZ:  taken = !zf;
            OP_BN:   taken = nf;
            OP_BNN:  taken = !nf;
            OP_BC:   taken = cf;
            OP_BNC:  taken = !cf;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag register, branch resolution and run/halt FSM.
// Latency 1 cycle; stall holds all state, flush injects a bubble, HALTED freezes until reset.
// Optional signed-overflow flag vf enabled by defining EX_MEM_VFLAG_EN.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int          WIDTH  = 16,
    parameter logic [15:0] NOP_IR = 16'h0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [15:0]      ex_ir,
    input  logic [WIDTH-1:0] ALUo,
    input  logic             cfout,
    input  logic [WIDTH-1:0] ex_store_data,
    output logic [15:0]      mem_ir,
    output logic [WIDTH-1:0] reg_C,
    output logic [WIDTH-1:0] smdr,
    output logic             cf,
    output logic             zf,
    output logic             nf,
    output logic             cfin,
    output logic [WIDTH-1:0] ALUi,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic             halted
`ifdef EX_MEM_VFLAG_EN
    ,
    input  logic             ex_a_msb,
    input  logic             ex_b_msb,
    output logic             vf
`endif
);

    run_state_t state;
    run_state_t state_nxt;
    logic [4:0] opcode;
    logic       take_branch;
    logic       res_zero;
    logic       res_neg;

    assign opcode   = ex_ir[15:11];
    assign res_zero = (ALUo == '0);
    assign res_neg  = ALUo[WIDTH-1];

    ex_mem_stage_branch_resolve u_branch_resolve (
        .opcode (opcode),
        .zf     (zf),
        .nf     (nf),
        .cf     (cf),
        .taken  (take_branch)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // HALT only takes effect when it actually moves into MEM.
    always_comb begin
        state_nxt = state;
        if ((state == ST_RUN) && !flush && !stall && (opcode == OP_HALT)) begin
            state_nxt = ST_HALTED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ir        <= NOP_IR;
            reg_C         <= '0;
            smdr          <= '0;
            cf            <= 1'b0;
            zf            <= 1'b0;
            nf            <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (state == ST_HALTED) begin
            mem_ir <= mem_ir;
        end else if (flush) begin
            mem_ir       <= NOP_IR;
            branch_taken <= 1'b0;
        end else if (!stall) begin
            mem_ir        <= ex_ir;
            reg_C         <= ALUo;
            smdr          <= ex_store_data;
            branch_taken  <= take_branch;
            branch_target <= ALUo;
            if (op_is_add(opcode) || op_is_sub(opcode)) begin
                cf <= cfout;
                zf <= res_zero;
                nf <= res_neg;
            end else if (op_is_logic(opcode)) begin
                zf <= res_zero;
                nf <= res_neg;
            end
        end
    end

`ifdef EX_MEM_VFLAG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            vf <= 1'b0;
        end else if ((state == ST_RUN) && !flush && !stall) begin
            if (op_is_add(opcode)) begin
                vf <= (ex_a_msb == ex_b_msb) && (res_neg != ex_a_msb);
            end else if (op_is_sub(opcode)) begin
                vf <= (ex_a_msb != ex_b_msb) && (res_neg != ex_a_msb);
            end
        end
    end
`endif

    assign cfin   = cf;
    assign ALUi   = reg_C;
    assign halted = (state == ST_HALTED);

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage of the 16-bit core. It sits directly downstream of the ALU.
- It registers the ALU result, the carry-out and the instruction word for the memory stage.
- It owns the architectural flag register (zf, nf, cf) and feeds cf back to the ALU carry-in.
- It resolves conditional branches and JMPR, and latches HALT into a two-state run/halt FSM.

Parameters:
- WIDTH, 16, datapath width; ALU result, store data and branch target.
- NOP_IR, 16'h0000, instruction word inserted on flush and reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- stall  in  1  hold every register this cycle.
- flush  in  1  kill the instruction currently in EX; load a bubble.
- ex_ir  in  16  instruction in EX; opcode is ex_ir[15:11].
- ALUo  in  WIDTH  ALU result.
- cfout  in  1  ALU carry/borrow out.
- ex_store_data  in  WIDTH  register value to be stored by STORE.
- mem_ir  out  16  registered instruction for MEM.
- reg_C  out  WIDTH  registered ALU result; also the memory address for LOAD/STORE.
- smdr  out  WIDTH  registered store data.
- cf, zf, nf  out  1 each  flag register.
- cfin  out  1  equals cf; drives ALU carry-in.
- ALUi  out  WIDTH  equals reg_C; drives ALU pass-through input.
- branch_taken  out  1  registered; redirect fetch this cycle.
- branch_target  out  WIDTH  registered target, equal to ALUo of the branch.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset values:
  - mem_ir = NOP_IR; reg_C = 0; smdr = 0.
  - cf = zf = nf = 0.
  - branch_taken = 0; branch_target = 0.
  - FSM = RUN; halted = 0.
- Priority at each edge: reset > HALTED freeze > flush > stall > normal update.
- Latency: one cycle from EX inputs to all registered outputs. cfin and ALUi are combinational copies of registers.
- Normal update (RUN, no flush, no stall):
  - mem_ir <= ex_ir; reg_C <= ALUo; smdr <= ex_store_data.
- Flag rules (use the opcode of ex_ir; flags take the pre-update value otherwise):
  - ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP update all three flags:
    - cf <= cfout;
    - zf <= (ALUo == 0);
    - nf <= ALUo[15].
  - AND, OR, XOR, SLL, SRL, SLA, SRA update zf and nf only; cf holds.
  - LOAD, STORE, LDIH, JMPR, branches, NOP and HALT leave all flags unchanged.
- Branch rules:
  - branch_taken <= 1 for:
    - JMPR unconditionally;
    - BZ when zf; BNZ when !zf;
    - BN when nf; BNN when !nf;
    - BC when cf; BNC when !cf.
  - Conditions use the flag register value before this edge. That value was written by the preceding instruction, so no bypass is needed.
  - branch_target <= ALUo.
  - branch_taken is otherwise 0. It is a single-cycle pulse unless stall holds it.
- Stall: every register holds, including flags and branch_taken.
- Flush:
  - mem_ir <= NOP_IR; branch_taken <= 0.
  - Flags, reg_C and smdr hold.
  - Flush with stall in the same cycle: flush wins.
- FSM states and transitions:
  - RUN to HALTED when a HALT opcode is latched (normal update).
  - HALTED: all registers frozen and halted = 1. Only reset exits.
  - Reset mid-HALTED returns to RUN with reset values.

Optional Feature:
- Macro: EX_MEM_VFLAG_EN.
- Defined:
  - Adds output vf (1 bit, reset 0) for signed overflow.
  - Updated only by the ADD and SUB families and CMP.
  - ADD family: vf is set when the operands have equal sign and the result sign differs.
  - SUB family and CMP: vf is set when the operands have differing sign and the result sign differs from A.
  - Adds inputs ex_a_msb and ex_b_msb (1 bit each) for these checks.
- Undefined: no vf port and no extra inputs; behaviour otherwise identical.

Decomposition:
- Opcode constants (LOAD…BNC, HALT, NOP) stay in the shared define.v include; no new opcodes are introduced.
- Add FLAG_* bit-index constants and NOP_IR to define.v.
- One natural sub-module, branch_resolve: a combinational map from opcode and flags to taken. It is reused by the future hazard unit.

Test Plan:
- Reset with ex_ir=ADD, ALUo=16'h1234 -> after the edge: mem_ir=0, reg_C=0, all flags 0, halted=0.
- SUB, ALUo=16'h0000, cfout=1 -> zf=1, nf=0, cf=1. Next XOR, ALUo=16'h8000, cfout=0 -> zf=0, nf=1, cf stays 1.
- CMP sets zf=1, then BZ with ALUo=16'h0040 -> branch_taken=1 for one cycle, branch_target=16'h0040. Repeat with BNZ -> branch_taken=0.
- ADD with stall=1 and flush=1 together -> mem_ir=0, flags unchanged, branch_taken=0. With stall=1 alone -> all outputs hold for three cycles.
- HALT latched, then ADD with ALUo=16'h0005 -> halted=1 and mem_ir stays HALT. Assert reset -> RUN, outputs at reset values.
- With EX_MEM_VFLAG_EN: ADD 16'h7FFF + 1, ALUo=16'h8000, a_msb=0, b_msb=0 -> vf=1, nf=1, cf=0.
